// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter (EXU/LSU round-robin) with a per-register busy scoreboard.
// Optional same-cycle bypass of granted writeback data is enabled by REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned REG_CNT    = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_issue_valid,
  input  logic                  i_issue_wen,
  input  logic [ADDR_WIDTH-1:0] i_issue_rd,
  input  logic [ADDR_WIDTH-1:0] i_rs1,
  input  logic [ADDR_WIDTH-1:0] i_rs2,
  output logic                  o_hazard,
  input  logic                  i_exu_valid,
  input  logic [ADDR_WIDTH-1:0] i_exu_rd,
  input  logic [DATA_WIDTH-1:0] i_exu_data,
  output logic                  o_exu_ready,
  input  logic                  i_lsu_valid,
  input  logic [ADDR_WIDTH-1:0] i_lsu_rd,
  input  logic [DATA_WIDTH-1:0] i_lsu_data,
  output logic                  o_lsu_ready,
  output logic                  o_rf_wen,
  output logic [ADDR_WIDTH-1:0] o_rf_rd,
  output logic [DATA_WIDTH-1:0] o_rf_wdata,
  output logic                  o_fwd1_valid,
  output logic [DATA_WIDTH-1:0] o_fwd1_data,
  output logic                  o_fwd2_valid,
  output logic [DATA_WIDTH-1:0] o_fwd2_data
);

  typedef enum logic {GntExu, GntLsu} src_e;

  src_e                  r_last_grant;
  logic [REG_CNT-1:0]    r_busy;
  logic                  r_rf_wen;
  logic [ADDR_WIDTH-1:0] r_rf_rd;
  logic [DATA_WIDTH-1:0] r_rf_wdata;

  logic                  w_conflict;
  logic                  w_gnt_exu;
  logic                  w_gnt_lsu;
  logic                  w_grant;
  logic [ADDR_WIDTH-1:0] w_gnt_rd;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                  w_gnt_wr;
  logic                  w_issue_set;
  logic [REG_CNT-1:0]    w_busy_d;
  logic                  w_fwd1_hit;
  logic                  w_fwd2_hit;

  // LSU wins a conflict unless it won the previous one.
  assign w_conflict = i_exu_valid & i_lsu_valid;
  assign w_gnt_lsu  = i_lsu_valid & (~i_exu_valid | (r_last_grant == GntExu));
  assign w_gnt_exu  = i_exu_valid & ~w_gnt_lsu;
  assign w_grant    = w_gnt_exu | w_gnt_lsu;
  assign w_gnt_rd   = w_gnt_lsu ? i_lsu_rd : i_exu_rd;
  assign w_gnt_data = w_gnt_lsu ? i_lsu_data : i_exu_data;
  assign w_gnt_wr   = w_grant & (w_gnt_rd != '0);

  assign o_exu_ready = w_gnt_exu;
  assign o_lsu_ready = w_gnt_lsu;

  assign w_issue_set = i_issue_valid & i_issue_wen & (i_issue_rd != '0);

  always_comb begin
    w_busy_d = r_busy;
    if (w_gnt_wr) w_busy_d[w_gnt_rd] = 1'b0;
    if (w_issue_set) w_busy_d[i_issue_rd] = 1'b1;
    w_busy_d[0] = 1'b0;
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign w_fwd1_hit   = w_gnt_wr & (w_gnt_rd == i_rs1);
  assign w_fwd2_hit   = w_gnt_wr & (w_gnt_rd == i_rs2);
  assign o_fwd1_data  = w_fwd1_hit ? w_gnt_data : '0;
  assign o_fwd2_data  = w_fwd2_hit ? w_gnt_data : '0;
`else
  assign w_fwd1_hit   = 1'b0;
  assign w_fwd2_hit   = 1'b0;
  assign o_fwd1_data  = '0;
  assign o_fwd2_data  = '0;
`endif
  assign o_fwd1_valid = w_fwd1_hit;
  assign o_fwd2_valid = w_fwd2_hit;

  assign o_hazard = (r_busy[i_rs1] & ~w_fwd1_hit) | (r_busy[i_rs2] & ~w_fwd2_hit) |
                    (i_issue_wen & r_busy[i_issue_rd]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy       <= '0;
      r_last_grant <= GntExu;
      r_rf_wen     <= 1'b0;
      r_rf_rd      <= '0;
      r_rf_wdata   <= '0;
    end else begin
      r_busy   <= w_busy_d;
      r_rf_wen <= w_gnt_wr;
      if (w_grant) begin
        r_rf_rd    <= w_gnt_rd;
        r_rf_wdata <= w_gnt_data;
      end
      if (w_conflict) r_last_grant <= w_gnt_lsu ? GntLsu : GntExu;
    end
  end

  assign o_rf_wen   = r_rf_wen;
  assign o_rf_rd    = r_rf_rd;
  assign o_rf_wdata = r_rf_wdata;

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(i_issue_valid && o_hazard))
        else $error("issue while hazard asserted");
      assert (!(w_gnt_wr && !r_busy[w_gnt_rd]))
        else $error("writeback to non-busy register %0d", w_gnt_rd);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; bypass expectations follow REGFILE_WB_BYPASS_EN.
module tb_regfile_wb_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid, issue_wen;
  logic [AW-1:0] issue_rd, rs1, rs2;
  logic          hazard;
  logic          exu_valid, exu_ready, lsu_valid, lsu_ready;
  logic [AW-1:0] exu_rd, lsu_rd;
  logic [DW-1:0] exu_data, lsu_data;
  logic          rf_wen;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_wdata;
  logic          fwd1_valid, fwd2_valid;
  logic [DW-1:0] fwd1_data, fwd2_data;

  int n_checks = 0;
  int n_errors = 0;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_CNT(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_issue_valid(issue_valid),
    .i_issue_wen  (issue_wen),
    .i_issue_rd   (issue_rd),
    .i_rs1        (rs1),
    .i_rs2        (rs2),
    .o_hazard     (hazard),
    .i_exu_valid  (exu_valid),
    .i_exu_rd     (exu_rd),
    .i_exu_data   (exu_data),
    .o_exu_ready  (exu_ready),
    .i_lsu_valid  (lsu_valid),
    .i_lsu_rd     (lsu_rd),
    .i_lsu_data   (lsu_data),
    .o_lsu_ready  (lsu_ready),
    .o_rf_wen     (rf_wen),
    .o_rf_rd      (rf_rd),
    .o_rf_wdata   (rf_wdata),
    .o_fwd1_valid (fwd1_valid),
    .o_fwd1_data  (fwd1_data),
    .o_fwd2_valid (fwd2_valid),
    .o_fwd2_data  (fwd2_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_rd    = rd;
    tick();
    issue_valid = 1'b0;
    issue_wen   = 1'b0;
    issue_rd    = '0;
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_wen", rf_wen, 0);
    check("rst_rd", rf_rd, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_hazard", hazard, 0);
    check("rst_fwd1", fwd1_valid, 0);

    // 1: lone EXU writeback
    issue(5);
    exu_valid = 1'b1; exu_rd = 5; exu_data = 64'h11;
    #1;
    check("t1_exu_ready", exu_ready, 1);
    check("t1_lsu_ready", lsu_ready, 0);
    tick();
    exu_valid = 1'b0;
    #1;
    check("t1_wen", rf_wen, 1);
    check("t1_rd", rf_rd, 5);
    check("t1_wdata", rf_wdata, 64'h11);
    tick();
    check("t1_idle_wen", rf_wen, 0);

    // 2: sustained conflict alternates, LSU first
    issue(3); issue(4); issue(8); issue(10);
    exu_valid = 1'b1; exu_rd = 3; exu_data = 64'hA;
    lsu_valid = 1'b1; lsu_rd = 4; lsu_data = 64'hB;
    #1;
    check("t2a_lsu_ready", lsu_ready, 1);
    check("t2a_exu_ready", exu_ready, 0);
    tick();
    lsu_rd = 8; lsu_data = 64'hC;
    #1;
    check("t2a_rd", rf_rd, 4);
    check("t2a_wdata", rf_wdata, 64'hB);
    check("t2b_exu_ready", exu_ready, 1);
    check("t2b_lsu_ready", lsu_ready, 0);
    tick();
    exu_rd = 10; exu_data = 64'hD;
    #1;
    check("t2b_rd", rf_rd, 3);
    check("t2b_wdata", rf_wdata, 64'hA);
    check("t2c_lsu_ready", lsu_ready, 1);
    tick();
    lsu_valid = 1'b0;
    #1;
    check("t2c_rd", rf_rd, 8);
    check("t2d_exu_ready", exu_ready, 1);
    tick();
    exu_valid = 1'b0;
    #1;
    check("t2d_rd", rf_rd, 10);
    check("t2d_wdata", rf_wdata, 64'hD);

    // 3: RAW on rd=7 resolved by LSU writeback
    issue(7);
    rs1 = 7;
    #1;
    check("t3_hazard_a", hazard, 1);
    tick();
    check("t3_hazard_b", hazard, 1);
    rs2 = 7;
    lsu_valid = 1'b1; lsu_rd = 7; lsu_data = 64'h77;
    #1;
    check("t3_grant_hazard", hazard, Bypass ? 0 : 1);
    check("t3_fwd1_valid", fwd1_valid, Bypass ? 1 : 0);
    check("t3_fwd1_data", fwd1_data, Bypass ? 64'h77 : 0);
    check("t3_fwd2_valid", fwd2_valid, Bypass ? 1 : 0);
    tick();
    lsu_valid = 1'b0;
    #1;
    check("t3_after_hazard", hazard, 0);
    check("t3_wen", rf_wen, 1);
    check("t3_rd", rf_rd, 7);
    rs1 = '0; rs2 = '0;

    // 4: write to x0 is accepted but suppressed
    exu_valid = 1'b1; exu_rd = 0; exu_data = 64'hFF;
    #1;
    check("t4_exu_ready", exu_ready, 1);
    tick();
    exu_valid = 1'b0;
    issue_wen = 1'b1; issue_rd = 0;
    #1;
    check("t4_wen", rf_wen, 0);
    check("t4_x0_hazard", hazard, 0);
    issue_wen = 1'b0;

    // 5: WAW stall, then simultaneous set/clear of different rds
    issue(9); issue(2);
    issue_wen = 1'b1; issue_rd = 9;
    #1;
    check("t5_waw", hazard, 1);
    issue_valid = 1'b1; issue_rd = 6;
    lsu_valid = 1'b1; lsu_rd = 2; lsu_data = 64'h22;
    #1;
    check("t5_issue_hazard", hazard, 0);
    check("t5_lsu_ready", lsu_ready, 1);
    tick();
    issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = '0;
    lsu_valid = 1'b0;
    rs1 = 2;
    #1;
    check("t5_clear2", hazard, 0);
    check("t5_wen", rf_wen, 1);
    check("t5_rd", rf_rd, 2);
    rs1 = 6;
    #1;
    check("t5_set6", hazard, 1);
    rs1 = 9; rs2 = 6;

    // 6: reset in the grant cycle
    exu_valid = 1'b1; exu_rd = 9; exu_data = 64'h99;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exu_valid = 1'b0;
    issue_wen = 1'b1; issue_rd = 9;
    #1;
    check("t6_wen", rf_wen, 0);
    check("t6_rd", rf_rd, 0);
    check("t6_hazard", hazard, 0);
    issue_wen = 1'b0; rs1 = '0; rs2 = '0;
    issue(11); issue(12);
    exu_valid = 1'b1; exu_rd = 11; exu_data = 64'h1;
    lsu_valid = 1'b1; lsu_rd = 12; lsu_data = 64'h2;
    #1;
    check("t6_rr_lsu_first", lsu_ready, 1);
    tick();
    lsu_valid = 1'b0;
    #1;
    check("t6_rr_exu_next", exu_ready, 1);
    tick();
    exu_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
